// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - arb_state_e : arbiter FSM encodings (IDLE/BUSY/DONE/CANCEL)
//   - SIZE_*      : access size encodings carried on ch_size / mem_size
//   - KSEG_*      : kseg0/kseg1 to physical address folding constants
//   - kseg_xlate  : helper applying the optional address fold
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_DONE   = 2'd2,
    ST_CANCEL = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // addr[31] marks kseg0/kseg1; both fold onto the low 512 MB physical window.
  localparam int          KSEG_SEL_BIT   = 31;
  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

  function automatic logic [31:0] kseg_xlate(input logic [31:0] addr,
                                             input logic        en);
    if (en && addr[KSEG_SEL_BIT]) begin
      return addr & KSEG_PHYS_MASK;
    end
    return addr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational N-way selector.
//   mask  : candidate channels (one bit per channel)
//   ptr   : last granted channel (used only when RR_EN != 0)
//   valid : at least one candidate present
//   index : chosen channel
// RR_EN == 0 : lowest index wins.
// RR_EN != 0 : search ptr+1 .. ptr+NCH modulo NCH, first hit wins.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int RR_EN = 0,
  parameter int IW    = 1
) (
  input  logic [NCH-1:0] mask,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  index
);

  int          cand_i;
  logic [IW-1:0] cand_idx;

  // Walk candidates from lowest to highest priority so the last hit,
  // i.e. the highest-priority requester, is the one that sticks.
  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand_i   = 0;
    cand_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand_i = (RR_EN != 0) ? int'(ptr) + k : k - 1;
      if (cand_i >= NCH) begin
        cand_i = cand_i - NCH;
      end
      cand_idx = cand_i[IW-1:0];
      if (mask[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter multiplexing SRAM-like requesters onto one mem_* port.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   ch_req/write/size/sel/addr/wdata : per-channel request fields (packed)
//   ch_flush               : per-channel cancel of pending/in-flight request
//   ch_ready               : one-cycle, one-hot completion pulse
//   ch_rdata               : load data, valid while ch_ready is high
//   ch_stall               : ch_req & ~ch_ready
//   mem_a/access/write/size/sel/st_data : registered downstream request
//   mem_data, mem_ready    : downstream response
//   mem_flush              : one-cycle downstream cancel
//   dbg_state              : current FSM state (arb_state_e encoding)
// Handshake: a channel raises ch_req with its fields and holds them until it
// sees ch_ready; the arbiter samples the fields once at grant and holds
// mem_access plus all mem_* fields constant until mem_ready (completion) or
// a flush of the granted channel (cancel, no ch_ready follows).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int RR_EN      = 0,
  parameter int KSEG_XLATE = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_write,
  input  logic [2*NCH-1:0]  ch_size,
  input  logic [4*NCH-1:0]  ch_sel,
  input  logic [32*NCH-1:0] ch_addr,
  input  logic [32*NCH-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_flush,
  output logic [NCH-1:0]    ch_ready,
  output logic [31:0]       ch_rdata,
  output logic [NCH-1:0]    ch_stall,
  output logic [31:0]       mem_a,
  output logic              mem_access,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_st_data,
  input  logic [31:0]       mem_data,
  input  logic              mem_ready,
  output logic              mem_flush,
  output logic [1:0]        dbg_state
);

  localparam int IW = $clog2(NCH);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [NCH-1:0] cand_mask;
  logic [NCH-1:0] grant_oh;

  logic [31:0] addr_a  [NCH];
  logic [31:0] wdata_a [NCH];
  logic [1:0]  size_a  [NCH];
  logic [3:0]  sel_a   [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_a[g]  = ch_addr[g*32 +: 32];
    assign wdata_a[g] = ch_wdata[g*32 +: 32];
    assign size_a[g]  = ch_size[g*2 +: 2];
    assign sel_a[g]   = ch_sel[g*4 +: 4];
  end

  // A flushed channel never wins arbitration, even if ch_req is still high.
  assign cand_mask = ch_req & ~ch_flush;
  assign grant_oh  = NCH'(1) << grant_q;
  assign ch_stall  = ch_req & ~ch_ready;
  assign dbg_state = state_q;

  mem_port_arbiter_rr_picker #(
    .NCH   (NCH),
    .RR_EN (RR_EN),
    .IW    (IW)
  ) u_picker (
    .mask  (cand_mask),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion has priority over flush when both arrive in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (mem_ready)               state_d = ST_DONE;
        else if (ch_flush[grant_q])  state_d = ST_CANCEL;
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_CANCEL: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q     <= '0;
      ptr_q       <= IW'(NCH - 1);
      mem_a       <= '0;
      mem_access  <= 1'b0;
      mem_write   <= 1'b0;
      mem_size    <= SIZE_B;
      mem_sel     <= '0;
      mem_st_data <= '0;
      mem_flush   <= 1'b0;
      ch_ready    <= '0;
      ch_rdata    <= '0;
    end else begin
      mem_flush <= 1'b0;
      ch_ready  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_idx;
            mem_a       <= kseg_xlate(addr_a[pick_idx], KSEG_XLATE != 0);
            mem_write   <= ch_write[pick_idx];
            mem_size    <= size_a[pick_idx];
            mem_sel     <= sel_a[pick_idx];
            mem_st_data <= wdata_a[pick_idx];
            mem_access  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            mem_access <= 1'b0;
            ch_ready   <= grant_oh;
            // Stores leave the last load data visible.
            if (!mem_write) ch_rdata <= mem_data;
          end else if (ch_flush[grant_q]) begin
            mem_access <= 1'b0;
            mem_flush  <= 1'b1;
          end
        end
        ST_DONE, ST_CANCEL: begin
          // Cancelled channels also move the pointer so they lose priority.
          ptr_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule
